// File: rtl/menu_pkg.sv
// rtl/menu_pkg.sv - shared constants and fetch FSM encoding for the menu overlay
package menu_pkg;

  localparam logic [10:0] TXT_BASE  = 11'h000;
  localparam logic [10:0] FONT_BASE = 11'h400;
  localparam logic [10:0] LOGO_BASE = 11'h380;

  localparam int CELL_W = 8;
  localparam int CELL_H = 8;

  typedef enum logic [2:0] {IDLE, TXT, TWAIT, FONT, FWAIT} fetch_state_t;

endpackage

// File: rtl/menu_cell_fetch.sv
// rtl/menu_cell_fetch.sv - per-cell char code and font row fetch from BRAM port B
module menu_cell_fetch
  import menu_pkg::*;
#(
  parameter int COLS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pix_ce,
  input  logic        start,
  input  logic [7:0]  col,
  input  logic [7:0]  crow,
  input  logic [2:0]  frow,
  output logic [10:0] mem_addr,
  output logic        mem_ce,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  bits,
  output logic        done,
  output logic        busy
);

  fetch_state_t state, state_n;
  logic [7:0]   col_q, crow_q;
  logic [2:0]   frow_q;
  logic [6:0]   code;
  logic [10:0]  txt_addr;

  assign txt_addr = TXT_BASE + 11'(crow_q) * 11'(COLS) + 11'(col_q);
  assign busy     = (state != IDLE);

  // Cell coordinates are latched at start because x keeps moving during the fetch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      col_q  <= '0;
      crow_q <= '0;
      frow_q <= '0;
      code   <= '0;
      bits   <= '0;
    end else if (pix_ce) begin
      state <= state_n;
      if (state == IDLE && start) begin
        col_q  <= col;
        crow_q <= crow;
        frow_q <= frow;
      end
      if (state == TWAIT) code <= mem_dout[6:0];
      if (state == FWAIT) bits <= mem_dout;
    end
  end

  always_comb begin
    state_n  = state;
    mem_addr = '0;
    mem_ce   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_n = TXT;
      TXT: begin
        mem_addr = txt_addr;
        mem_ce   = pix_ce;
        state_n  = TWAIT;
      end
      TWAIT: state_n = FONT;
      FONT: begin
        mem_addr = FONT_BASE | {1'b0, code, frow_q};
        mem_ce   = pix_ce;
        state_n  = FWAIT;
      end
      FWAIT: begin
        done    = pix_ce;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/menu_text_render.sv
// rtl/menu_text_render.sv - 32x28 text overlay renderer reading the menu BRAM port B
module menu_text_render
  import menu_pkg::*;
#(
  parameter int OX   = 64,
  parameter int OY   = 8,
  parameter int COLS = 32,
  parameter int ROWS = 28
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pix_ce,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        en,
  input  logic        hl_en,
  input  logic [4:0]  hl_row,
  output logic [10:0] mem_addr,
  output logic        mem_ce,
  input  logic [7:0]  mem_dout,
  output logic        ovl_de,
  output logic        ovl_pix
);

  logic [10:0] rx, ry;
  logic [7:0]  pre_col, crow;
  logic [2:0]  px, frow;
  logic        col_ok, row_ok, in_win, start;
  logic [18:0] cell_tag, fetch_tag;
  logic        next_valid, inv, de_cell;
  logic [7:0]  shift, bits;
  logic        done, busy;

  // Out-of-window coordinates wrap to large unsigned values and fail the range checks.
  assign rx       = x - 11'(OX);
  assign ry       = y - 11'(OY);
  assign px       = rx[2:0];
  assign pre_col  = rx[10:3] + 8'd1;
  assign crow     = ry[10:3];
  assign frow     = ry[2:0];
  assign col_ok   = pre_col < 8'(COLS);
  assign row_ok   = crow < 8'(ROWS);
  assign in_win   = (rx < 11'(COLS * CELL_W)) && (ry < 11'(ROWS * CELL_H));
  assign start    = pix_ce && (px == 3'd0) && col_ok && row_ok;
  assign cell_tag = {pre_col, crow, frow};

  menu_cell_fetch #(.COLS(COLS)) u_fetch (
    .clk      (clk),
    .resetn   (resetn),
    .pix_ce   (pix_ce),
    .start    (start),
    .col      (pre_col),
    .crow     (crow),
    .frow     (frow),
    .mem_addr (mem_addr),
    .mem_ce   (mem_ce),
    .mem_dout (mem_dout),
    .bits     (bits),
    .done     (done),
    .busy     (busy)
  );

  // A prefetched row is used only if it was fetched for exactly the cell now starting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_tag  <= '0;
      next_valid <= 1'b0;
      shift      <= '0;
      inv        <= 1'b0;
      de_cell    <= 1'b0;
      ovl_de     <= 1'b0;
      ovl_pix    <= 1'b0;
    end else if (pix_ce) begin
      if (start && !busy) fetch_tag <= cell_tag;
      if (px == 3'd7) begin
        shift      <= (next_valid && fetch_tag == cell_tag) ? bits : 8'h00;
        next_valid <= 1'b0;
        inv        <= hl_en && (crow == 8'(hl_row));
        de_cell    <= en && col_ok && row_ok;
      end
      if (done) next_valid <= 1'b1;
      ovl_de  <= de_cell && in_win;
      ovl_pix <= de_cell && in_win && (shift[px] ^ inv);
    end
  end

endmodule
